// File: rtl/rv32_mod_instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mod_instruction_prefetch
// Purpose  : Prefetching instruction-fetch unit for the RV32 hart. A request
//            engine fetches sequential words ahead of the hart into a
//            registered, address-tagged FIFO. It issues requests only while
//            buffer space exists, supports PC redirect/flush, and records
//            bus errors per entry.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1   clock
//   reset            in   1   synchronous, active-high reset
//   if_redirect      in   1   flush FIFO, restart fetching at if_redirect_addr
//   if_redirect_addr in  32   new fetch address (bits [1:0] treated as 0)
//   if_ready         in   1   hart consumes head entry when if_valid is high
//   if_instruction   out 32   head data, or INSTR_NOP (empty / error entry)
//   if_address       out 32   fetch address tag of the head entry
//   if_valid         out  1   FIFO non-empty
//   if_error         out  1   head entry was fetched with a bus error
//   instr_req        out  1   bus request (registered)
//   instr_ack        in   1   bus acknowledge, data valid this cycle
//   instr_err        in   1   bus error, terminates the request like an ack
//   instr_addr       out 32   bus address (registered, word aligned)
//   instr_data_i     in  32   bus read data
// ============================================================================
module rv32_mod_instruction_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] INSTR_NOP  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_addr,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_address,
    output logic        if_valid,
    output logic        if_error,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic        instr_err,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [31:0]        c_WORD      = 32'd4;
    localparam logic [31:0]        c_ALIGN     = 32'hFFFF_FFFC;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Pointer wrap relies on natural binary overflow of the pointers.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_instr_req;
    logic [31:0]         r_instr_addr;
    logic [31:0]         r_fetch_addr;

    logic [31:0]         r_fifo_addr [0:DEPTH-1];
    logic [31:0]         r_fifo_data [0:DEPTH-1];
    logic                r_fifo_err  [0:DEPTH-1];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_next;
    logic                w_req_next;
    logic [31:0]         w_addr_next;
    logic [31:0]         w_fetch_next;
    logic                w_push;
    logic [31:0]         w_push_data;
    logic                w_push_err;

    logic [31:0]         w_redirect_addr;
    logic                w_resp;
    logic                w_resp_err;
    logic                w_resp_ack;
    logic                w_pop;
    logic                w_has_room;
    logic                w_room_after_push;
    logic [c_CNT_W-1:0]  w_count_after_push;

    // Masking (rather than slicing) keeps every redirect address bit in use.
    assign w_redirect_addr = if_redirect_addr & c_ALIGN;

    // Responses only count while a request is actually outstanding, so a
    // stray ack after reset or after a dropped request is ignored.
    assign w_resp     = r_instr_req & (instr_ack | instr_err);
    assign w_resp_err = r_instr_req & instr_err;
    assign w_resp_ack = r_instr_req & instr_ack & ~instr_err;

    assign w_pop      = (r_count != '0) & if_ready;
    assign w_has_room = (r_count < c_DEPTH_CNT);

    // Occupancy after an ack is pushed, accounting for a same-cycle pop.
    assign w_count_after_push = r_count + c_CNT_ONE - (w_pop ? c_CNT_ONE : '0);
    assign w_room_after_push  = (w_count_after_push < c_DEPTH_CNT);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (if_redirect) begin
            // A response this cycle closes the old transfer, so the new
            // address can be requested immediately; otherwise an
            // outstanding request must be drained first.
            if (w_resp) begin
                w_state_next = c_ST_REQ;
            end else if (r_instr_req) begin
                w_state_next = c_ST_DRAIN;
            end else begin
                w_state_next = c_ST_IDLE;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_has_room) begin
                        w_state_next = c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (w_resp_err) begin
                        w_state_next = c_ST_HALT;
                    end else if (w_resp_ack && !w_room_after_push) begin
                        w_state_next = c_ST_IDLE;
                    end
                end
                c_ST_HALT: begin
                    w_state_next = c_ST_HALT;
                end
                c_ST_DRAIN: begin
                    if (w_resp) begin
                        w_state_next = c_ST_REQ;
                    end
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (bus request / fetch address / FIFO push controls)
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_next   = r_instr_req;
        w_addr_next  = r_instr_addr;
        w_fetch_next = r_fetch_addr;
        w_push       = 1'b0;
        w_push_data  = instr_data_i;
        w_push_err   = 1'b0;

        if (if_redirect) begin
            w_fetch_next = w_redirect_addr;
            if (w_resp) begin
                w_req_next  = 1'b1;
                w_addr_next = w_redirect_addr;
            end
            // With no response the request (if any) is held unchanged.
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_has_room) begin
                        w_req_next  = 1'b1;
                        w_addr_next = r_fetch_addr;
                    end
                end
                c_ST_REQ: begin
                    if (w_resp_err) begin
                        w_push      = 1'b1;
                        w_push_data = INSTR_NOP;
                        w_push_err  = 1'b1;
                        w_req_next  = 1'b0;
                    end else if (w_resp_ack) begin
                        w_push       = 1'b1;
                        w_fetch_next = r_fetch_addr + c_WORD;
                        if (w_room_after_push) begin
                            w_addr_next = r_instr_addr + c_WORD;
                        end else begin
                            w_req_next = 1'b0;
                        end
                    end
                end
                c_ST_HALT: begin
                    w_req_next = 1'b0;
                end
                c_ST_DRAIN: begin
                    // The stale response is dropped; fetch_addr already
                    // holds the redirect target.
                    if (w_resp) begin
                        w_req_next  = 1'b1;
                        w_addr_next = r_fetch_addr;
                    end
                end
                default: begin
                    w_req_next = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bus-side registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_req  <= 1'b0;
            r_instr_addr <= RESET_ADDR;
            r_fetch_addr <= RESET_ADDR;
        end else begin
            r_instr_req  <= w_req_next;
            r_instr_addr <= w_addr_next;
            r_fetch_addr <= w_fetch_next;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    // Entries are reset so the empty head reads RESET_ADDR / INSTR_NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= RESET_ADDR;
                r_fifo_data[i] <= INSTR_NOP;
                r_fifo_err[i]  <= 1'b0;
            end
        end else if (if_redirect) begin
            // Flush overrides any push or pop in the same cycle.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= r_instr_addr;
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_err[r_wr_ptr]  <= w_push_err;
                r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Hart-side outputs, all sourced from registers
    // ------------------------------------------------------------------------
    assign if_valid       = (r_count != '0);
    assign if_address     = r_fifo_addr[r_rd_ptr];
    assign if_error       = r_fifo_err[r_rd_ptr] & if_valid;
    assign if_instruction = (!if_valid || r_fifo_err[r_rd_ptr]) ? INSTR_NOP
                                                                : r_fifo_data[r_rd_ptr];

    assign instr_req  = r_instr_req;
    assign instr_addr = r_instr_addr;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mod_instruction_prefetch
// Purpose  : Directed self-checking bench for rv32_mod_instruction_prefetch
//            (DEPTH=4, RESET_ADDR=0, INSTR_NOP=0x13). Bus read data is the
//            request address XOR c_KEY so every word is distinguishable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mod_instruction_prefetch;

    localparam logic [31:0] c_KEY = 32'hCAFE_0000;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_redirect;
    logic [31:0] if_redirect_addr;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_address;
    logic        if_valid;
    logic        if_error;
    logic        instr_req;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_addr;
    logic [31:0] instr_data_i;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign instr_data_i = instr_addr ^ c_KEY;

    rv32_mod_instruction_prefetch dut (
        .clk              (clk),
        .reset            (reset),
        .if_redirect      (if_redirect),
        .if_redirect_addr (if_redirect_addr),
        .if_ready         (if_ready),
        .if_instruction   (if_instruction),
        .if_address       (if_address),
        .if_valid         (if_valid),
        .if_error         (if_error),
        .instr_req        (instr_req),
        .instr_ack        (instr_ack),
        .instr_err        (instr_err),
        .instr_addr       (instr_addr),
        .instr_data_i     (instr_data_i)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_redirect = 1'b0; if_redirect_addr = 32'h0;
        if_ready = 1'b0; instr_ack = 1'b0; instr_err = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must win over redirect, ready and a bus ack.
        reset = 1'b1; if_redirect = 1'b1; if_redirect_addr = 32'h400;
        if_ready = 1'b1; instr_ack = 1'b1; instr_err = 1'b0;
        cyc(); cyc();
        n_total++; if (instr_req !== 1'b0) $display("FAIL rst_req: got %h exp 0", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 00000000", instr_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %h exp 0", if_valid); else n_pass++;
        n_total++; if (if_error !== 1'b0) $display("FAIL rst_error: got %h exp 0", if_error); else n_pass++;
        n_total++; if (if_instruction !== c_NOP) $display("FAIL rst_instr: got %h exp %h", if_instruction, c_NOP); else n_pass++;
        n_total++; if (if_address !== 32'h0) $display("FAIL rst_ifaddr: got %h exp 00000000", if_address); else n_pass++;
        reset = 1'b0; if_redirect = 1'b0; if_ready = 1'b0; instr_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea;
        do_reset();
        instr_ack = 1'b1; if_ready = 1'b1;
        cyc();
        n_total++; if (instr_req !== 1'b1) $display("FAIL b2b_first_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h0) $display("FAIL b2b_first_addr: got %h exp 00000000", instr_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL b2b_first_valid: got %h exp 0", if_valid); else n_pass++;
        cyc();
        for (int k = 0; k < 6; k++) begin
            ea = 32'(4 * k);
            n_total++; if (instr_req !== 1'b1) $display("FAIL b2b_req[%0d]: got %h exp 1", k, instr_req); else n_pass++;
            n_total++; if (instr_addr !== ea + 32'd4) $display("FAIL b2b_addr[%0d]: got %h exp %h", k, instr_addr, ea + 32'd4); else n_pass++;
            n_total++; if (if_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %h exp 1", k, if_valid); else n_pass++;
            n_total++; if (if_address !== ea) $display("FAIL b2b_ifaddr[%0d]: got %h exp %h", k, if_address, ea); else n_pass++;
            n_total++; if (if_instruction !== (ea ^ c_KEY)) $display("FAIL b2b_instr[%0d]: got %h exp %h", k, if_instruction, ea ^ c_KEY); else n_pass++;
            cyc();
        end
        instr_ack = 1'b0; if_ready = 1'b0;
    endtask

    task automatic test_fill();
        int n_resp;
        logic [31:0] heads [3];
        heads[0] = 32'h8; heads[1] = 32'hC; heads[2] = 32'h10;
        do_reset();
        instr_ack = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 10; i++) begin
            if (instr_req === 1'b1 && instr_ack) n_resp++;
            cyc();
        end
        n_total++; if (n_resp !== 4) $display("FAIL fill_responses: got %0d exp 4", n_resp); else n_pass++;
        n_total++; if (instr_req !== 1'b0) $display("FAIL fill_req_off: got %h exp 0", instr_req); else n_pass++;
        n_total++; if (if_address !== 32'h0) $display("FAIL fill_head: got %h exp 00000000", if_address); else n_pass++;
        // Single pop pulse frees one slot, which triggers exactly one fetch of 0x10.
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        n_total++; if (if_address !== 32'h4) $display("FAIL fill_pop_head: got %h exp 00000004", if_address); else n_pass++;
        n_total++; if (instr_req !== 1'b0) $display("FAIL fill_pop_req: got %h exp 0", instr_req); else n_pass++;
        cyc();
        n_total++; if (instr_req !== 1'b1) $display("FAIL fill_refill_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h10) $display("FAIL fill_refill_addr: got %h exp 00000010", instr_addr); else n_pass++;
        cyc();
        n_total++; if (instr_req !== 1'b0) $display("FAIL fill_refull_req: got %h exp 0", instr_req); else n_pass++;
        instr_ack = 1'b0;
        // Four pops empty the FIFO: 4 entries were held.
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++; if (if_address !== heads[i]) $display("FAIL fill_drain[%0d]: got %h exp %h", i, if_address, heads[i]); else n_pass++;
        end
        cyc();
        n_total++; if (if_valid !== 1'b0) $display("FAIL fill_empty_valid: got %h exp 0", if_valid); else n_pass++;
        n_total++; if (if_instruction !== c_NOP) $display("FAIL fill_empty_instr: got %h exp %h", if_instruction, c_NOP); else n_pass++;
        if_ready = 1'b0;
    endtask

    task automatic test_redirect_drain();
        do_reset();
        cyc();
        instr_ack = 1'b1;
        cyc();
        instr_ack = 1'b0;
        n_total++; if (instr_addr !== 32'h4) $display("FAIL drn_pending_addr: got %h exp 00000004", instr_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b1) $display("FAIL drn_pre_valid: got %h exp 1", if_valid); else n_pass++;
        if_redirect = 1'b1; if_redirect_addr = 32'h8000_0102;
        cyc();
        if_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (instr_req !== 1'b1) $display("FAIL drn_hold_req[%0d]: got %h exp 1", i, instr_req); else n_pass++;
            n_total++; if (instr_addr !== 32'h4) $display("FAIL drn_hold_addr[%0d]: got %h exp 00000004", i, instr_addr); else n_pass++;
            n_total++; if (if_valid !== 1'b0) $display("FAIL drn_hold_valid[%0d]: got %h exp 0", i, if_valid); else n_pass++;
            if (i < 2) cyc();
        end
        instr_ack = 1'b1;
        cyc();
        n_total++; if (instr_addr !== 32'h8000_0100) $display("FAIL drn_new_addr: got %h exp 80000100", instr_addr); else n_pass++;
        n_total++; if (instr_req !== 1'b1) $display("FAIL drn_new_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL drn_discard: got %h exp 0", if_valid); else n_pass++;
        cyc();
        instr_ack = 1'b0;
        n_total++; if (if_address !== 32'h8000_0100) $display("FAIL drn_head_addr: got %h exp 80000100", if_address); else n_pass++;
        n_total++; if (if_instruction !== (32'h8000_0100 ^ c_KEY)) $display("FAIL drn_head_instr: got %h exp %h", if_instruction, 32'h8000_0100 ^ c_KEY); else n_pass++;
        n_total++; if (instr_addr !== 32'h8000_0104) $display("FAIL drn_next_addr: got %h exp 80000104", instr_addr); else n_pass++;
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        instr_ack = 1'b1; if_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        n_total++; if (instr_addr !== 32'hC) $display("FAIL rak_pending: got %h exp 0000000c", instr_addr); else n_pass++;
        n_total++; if (if_address !== 32'h8) $display("FAIL rak_head: got %h exp 00000008", if_address); else n_pass++;
        if_redirect = 1'b1; if_redirect_addr = 32'h200;
        cyc();
        if_redirect = 1'b0; instr_ack = 1'b0;
        n_total++; if (instr_addr !== 32'h200) $display("FAIL rak_new_addr: got %h exp 00000200", instr_addr); else n_pass++;
        n_total++; if (instr_req !== 1'b1) $display("FAIL rak_new_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rak_flushed: got %h exp 0", if_valid); else n_pass++;
        instr_ack = 1'b1;
        cyc();
        instr_ack = 1'b0; if_ready = 1'b0;
        n_total++; if (if_address !== 32'h200) $display("FAIL rak_head_addr: got %h exp 00000200", if_address); else n_pass++;
        n_total++; if (if_instruction !== (32'h200 ^ c_KEY)) $display("FAIL rak_head_instr: got %h exp %h", if_instruction, 32'h200 ^ c_KEY); else n_pass++;
    endtask

    task automatic test_error();
        do_reset();
        if_redirect = 1'b1; if_redirect_addr = 32'h20;
        cyc();
        if_redirect = 1'b0;
        n_total++; if (instr_req !== 1'b0) $display("FAIL err_idle_req: got %h exp 0", instr_req); else n_pass++;
        cyc();
        n_total++; if (instr_addr !== 32'h20) $display("FAIL err_req_addr: got %h exp 00000020", instr_addr); else n_pass++;
        instr_err = 1'b1;
        cyc();
        instr_err = 1'b0;
        n_total++; if (if_error !== 1'b1) $display("FAIL err_flag: got %h exp 1", if_error); else n_pass++;
        n_total++; if (if_instruction !== c_NOP) $display("FAIL err_instr: got %h exp %h", if_instruction, c_NOP); else n_pass++;
        n_total++; if (if_address !== 32'h20) $display("FAIL err_ifaddr: got %h exp 00000020", if_address); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (instr_req !== 1'b0) $display("FAIL err_halt_req[%0d]: got %h exp 0", i, instr_req); else n_pass++;
            cyc();
        end
        if_redirect = 1'b1; if_redirect_addr = 32'h100;
        cyc();
        if_redirect = 1'b0;
        n_total++; if (if_valid !== 1'b0) $display("FAIL err_flush_valid: got %h exp 0", if_valid); else n_pass++;
        n_total++; if (if_error !== 1'b0) $display("FAIL err_flush_error: got %h exp 0", if_error); else n_pass++;
        cyc();
        n_total++; if (instr_req !== 1'b1) $display("FAIL err_restart_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h100) $display("FAIL err_restart_addr: got %h exp 00000100", instr_addr); else n_pass++;
        // Ack and err together: err takes priority.
        instr_ack = 1'b1; instr_err = 1'b1;
        cyc();
        instr_ack = 1'b0; instr_err = 1'b0;
        n_total++; if (if_error !== 1'b1) $display("FAIL err_prio_flag: got %h exp 1", if_error); else n_pass++;
        n_total++; if (if_instruction !== c_NOP) $display("FAIL err_prio_instr: got %h exp %h", if_instruction, c_NOP); else n_pass++;
        n_total++; if (instr_req !== 1'b0) $display("FAIL err_prio_req: got %h exp 0", instr_req); else n_pass++;
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        if_redirect = 1'b1; if_redirect_addr = 32'h40;
        cyc();
        if_redirect = 1'b0;
        cyc();
        instr_ack = 1'b1;
        cyc();
        instr_ack = 1'b0;
        n_total++; if (instr_addr !== 32'h44) $display("FAIL rmr_pending: got %h exp 00000044", instr_addr); else n_pass++;
        reset = 1'b1;
        cyc();
        reset = 1'b0; instr_ack = 1'b1;
        n_total++; if (instr_req !== 1'b0) $display("FAIL rmr_req: got %h exp 0", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h0) $display("FAIL rmr_addr: got %h exp 00000000", instr_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rmr_valid: got %h exp 0", if_valid); else n_pass++;
        n_total++; if (if_address !== 32'h0) $display("FAIL rmr_ifaddr: got %h exp 00000000", if_address); else n_pass++;
        n_total++; if (if_instruction !== c_NOP) $display("FAIL rmr_instr: got %h exp %h", if_instruction, c_NOP); else n_pass++;
        cyc();
        n_total++; if (if_valid !== 1'b0) $display("FAIL rmr_ack_ignored: got %h exp 0", if_valid); else n_pass++;
        n_total++; if (instr_req !== 1'b1) $display("FAIL rmr_restart_req: got %h exp 1", instr_req); else n_pass++;
        n_total++; if (instr_addr !== 32'h0) $display("FAIL rmr_restart_addr: got %h exp 00000000", instr_addr); else n_pass++;
        cyc();
        instr_ack = 1'b0;
        n_total++; if (if_address !== 32'h0) $display("FAIL rmr_head: got %h exp 00000000", if_address); else n_pass++;
        n_total++; if (if_valid !== 1'b1) $display("FAIL rmr_head_valid: got %h exp 1", if_valid); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; if_redirect = 1'b0; if_redirect_addr = 32'h0;
        if_ready = 1'b0; instr_ack = 1'b0; instr_err = 1'b0;
        test_reset();
        test_back_to_back();
        test_fill();
        test_redirect_drain();
        test_redirect_with_ack();
        test_error();
        test_reset_mid_request();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32_mod_instruction_prefetch.md
Name: rv32_mod_instruction_prefetch

Overview:
Parametrised prefetching instruction-fetch unit for the RV32 hart. It replaces the combinational single-word fetch path with a registered, address-tagged FIFO. A request engine fetches sequential words ahead of the hart, requests only when buffer space exists, supports PC redirect/flush, and propagates bus errors per entry. It sits between the hart's fetch stage and the external instruction bus.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
RESET_ADDR, 32'h0000_0000, fetch address loaded at reset.
INSTR_NOP, 32'h0000_0013, value driven on if_instruction when the FIFO is empty or the head entry is an error (ADDI x0,x0,0).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_redirect  in  1  flush the FIFO and restart fetching at if_redirect_addr
if_redirect_addr  in  32  new fetch address; bits [1:0] are ignored and treated as 0
if_ready  in  1  hart consumes the head entry when if_valid is also high
if_instruction  out  32  head entry data, or INSTR_NOP
if_address  out  32  tag (fetch address) of the head entry
if_valid  out  1  FIFO is non-empty
if_error  out  1  head entry was fetched with instr_err
instr_req  out  1  bus request, registered
instr_ack  in  1  bus acknowledge; data is valid this cycle
instr_err  in  1  bus error response; terminates the request like an ack
instr_addr  out  32  bus address, registered, word aligned
instr_data_i  in  32  bus read data

Behaviour:
- Single clock domain, synchronous active-high reset; one clock and reset only.
- Reset values:
  - instr_req=0, instr_addr=RESET_ADDR, fetch_addr=RESET_ADDR.
  - FIFO empty (count=0), state IDLE.
  - if_valid=0, if_error=0, if_instruction=INSTR_NOP, if_address=RESET_ADDR.
- Reset wins over all other inputs. Reset mid-request abandons the transfer; any later ack or err is ignored until instr_req is next raised.
- FIFO entry layout is {addr[31:0], data[31:0], err}. The head is driven from registers, with no combinational path from instr_data_i to if_instruction.
- Bus handshake:
  - Only one request is outstanding at a time.
  - While instr_req=1, instr_addr stays stable.
  - A response is instr_req & (instr_ack | instr_err). If both instr_ack and instr_err are high, instr_err takes priority.
- States:
  - IDLE: enter REQ when count < DEPTH and no redirect is pending. instr_req rises on the next cycle with instr_addr=fetch_addr.
  - REQ, on ack:
    - Push {instr_addr, instr_data_i, 0} and set fetch_addr += 4.
    - Compute count' = count + 1 - pop.
    - If count' < DEPTH, keep instr_req=1 with instr_addr = old + 4 (back-to-back, one word per cycle). Otherwise drop instr_req and go to IDLE.
  - REQ, on err: push {instr_addr, INSTR_NOP, 1}, drop instr_req, go to HALT.
  - HALT: no requests are issued. Leave only on redirect.
  - DRAIN: a redirect arrived while a request was outstanding and not responding that cycle. Keep instr_req=1 with the old address until the response, then discard the response without pushing it. Next, go to REQ at fetch_addr (already equal to the redirect address).
- Redirect, in any state:
  - FIFO is flushed in the same edge (count=0), and fetch_addr <= {if_redirect_addr[31:2], 2'b00}.
  - A redirect coinciding with a response discards that response and goes straight to REQ at the new address.
  - A redirect overrides a simultaneous pop and push.
  - Outstanding-request cases: if no request is outstanding, go to IDLE; if one is outstanding with no response this cycle, go to DRAIN.
- Output side:
  - if_valid = (count != 0).
  - if_instruction = head.err ? INSTR_NOP : head.data. if_error = head.err & if_valid. if_address = head.addr.
  - A pop (if_valid & if_ready) advances the head on the edge.
  - if_ready with the FIFO empty is a no-op.
- Latency: a response at edge N makes if_valid=1 from edge N onward when the FIFO was empty, i.e. one cycle after the ack cycle.
- Full and simultaneous events:
  - A push never overflows, because requests are only issued when count < DEPTH.
  - A pop and a push in the same cycle keep count unchanged.
- Pointer wrap uses log2(DEPTH)-bit pointers plus a separate count of log2(DEPTH)+1 bits.

Test Plan:
- Reset then always-ack bus, if_ready=1 -> instr_addr sequence 0x0,0x4,0x8,... with instr_req continuously high; if_address tracks it one cycle later.
- DEPTH=4, if_ready=0, always-ack -> exactly 4 responses; instr_req=0 afterward; count=4. Then a single if_ready pulse -> one pop and one new request at 0x10.
- Redirect to 0x8000_0102 while a request to 0x4 is pending with ack delayed 3 cycles -> instr_req holds 0x4 until ack; data discarded; next request 0x8000_0100; FIFO empty meanwhile.
- Redirect in the same cycle as an ack for 0xC -> 0xC is never visible on if_address; next request is the redirect address.
- instr_err on 0x20 -> head shows if_error=1, if_instruction=0x0000_0013, if_address=0x20; no further requests until a redirect to 0x100 restarts fetching.
- Assert reset during an outstanding request with an ack arriving 1 cycle after reset -> all outputs at reset values; the ack is ignored; fetching restarts at RESET_ADDR.
